// File: rtl/parking_access_ctrl.sv
// Token-authenticated parking entry controller with slot occupancy tracking,
// bounded retries with timed lockout, and a peak/off-peak tariff latch.
module parking_access_ctrl #(
    parameter int unsigned       TOKEN_W     = 3,
    parameter int unsigned       TIME_W      = 8,
    parameter logic [TIME_W-1:0] PEAK_MASK   = TIME_W'(8'h1F),
    parameter int unsigned       MAX_TRIES   = 3,
    parameter int unsigned       LOCK_CYCLES = 16,
    parameter int unsigned       SLOTS       = 4,
    parameter int unsigned       CNT_W       = $clog2(SLOTS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               request,
    input  logic               confirm,
    input  logic [TOKEN_W-1:0] system_token,
    input  logic [TOKEN_W-1:0] user_token,
    input  logic [TIME_W-1:0]  TimeData,
    input  logic               car_exit,
    output logic               RegP,
    output logic               RegQ,
    output logic               grant,
    output logic               deny,
    output logic               locked,
    output logic [CNT_W-1:0]   occupied,
    output logic               full,
    output logic [2:0]         state
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AUTH  = 3'd1,
        ARMED = 3'd2,
        BILL  = 3'd3,
        DENY  = 3'd4,
        LOCK  = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [TRY_W-1:0]   tries_q;
    logic [TRY_W-1:0]   tries_n;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_n;
    logic [CNT_W-1:0]   occ_n;
    logic               confirm_q;
    logic               cfe;
    logic               peak;
    logic               grant_n;
    logic               reg_p_n;
    logic               reg_q_n;

    assign cfe   = confirm & ~confirm_q;
    assign peak  = ((TimeData & PEAK_MASK) == PEAK_MASK);
    assign full  = (occupied == CNT_W'(SLOTS));
    assign state = state_q;

    // Next-state, retry/lockout bookkeeping, tariff latch and occupancy
    always_comb begin
        state_n = state_q;
        tries_n = tries_q;
        timer_n = timer_q;
        reg_p_n = RegP;
        reg_q_n = RegQ;
        grant_n = 1'b0;
        occ_n   = occupied;

        case (state_q)
            IDLE: begin
                if (request) state_n = AUTH;
            end
            AUTH: begin
                if (!request) begin
                    state_n = IDLE;
                end else if (cfe) begin
                    if (full) begin
                        state_n = DENY;
                    end else if (user_token == system_token) begin
                        state_n = ARMED;
                        tries_n = '0;
                    end else if (tries_q + TRY_W'(1) == TRY_W'(MAX_TRIES)) begin
                        state_n = LOCK;
                        timer_n = TMR_W'(LOCK_CYCLES);
                        tries_n = '0;
                    end else begin
                        state_n = DENY;
                        tries_n = tries_q + TRY_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!request) begin
                    state_n = IDLE;
                end else if (cfe) begin
                    if (full) begin
                        state_n = DENY;
                    end else begin
                        state_n = BILL;
                        grant_n = 1'b1;
                        reg_p_n = peak;
                        reg_q_n = ~peak;
                    end
                end
            end
            BILL, DENY: begin
                if (!request) state_n = IDLE;
            end
            LOCK: begin
                timer_n = timer_q - TMR_W'(1);
                if (timer_q == TMR_W'(1)) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Returning to IDLE always drops the tariff selection
        if (state_n == IDLE) begin
            reg_p_n = 1'b0;
            reg_q_n = 1'b0;
        end

        if (grant_n && !car_exit) begin
            occ_n = occupied + CNT_W'(1);
        end else if (!grant_n && car_exit && (occupied != '0)) begin
            occ_n = occupied - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            tries_q   <= '0;
            timer_q   <= '0;
            confirm_q <= 1'b0;
            RegP      <= 1'b0;
            RegQ      <= 1'b0;
            grant     <= 1'b0;
            deny      <= 1'b0;
            locked    <= 1'b0;
            occupied  <= '0;
        end else begin
            state_q   <= state_n;
            tries_q   <= tries_n;
            timer_q   <= timer_n;
            confirm_q <= confirm;
            RegP      <= reg_p_n;
            RegQ      <= reg_q_n;
            grant     <= grant_n;
            deny      <= (state_n == DENY);
            locked    <= (state_n == LOCK);
            occupied  <= occ_n;
        end
    end

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Directed bench for parking_access_ctrl: session flow, tariff, lockout,
// capacity blocking, occupancy corner cases and mid-operation reset.
module tb_parking_access_ctrl;

    logic       clock;
    logic       reset;
    logic       request;
    logic       confirm;
    logic [2:0] system_token;
    logic [2:0] user_token;
    logic [7:0] TimeData;
    logic       car_exit;
    logic       RegP;
    logic       RegQ;
    logic       grant;
    logic       deny;
    logic       locked;
    logic [2:0] occupied;
    logic       full;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int lock_cnt;

    parking_access_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .request      (request),
        .confirm      (confirm),
        .system_token (system_token),
        .user_token   (user_token),
        .TimeData     (TimeData),
        .car_exit     (car_exit),
        .RegP         (RegP),
        .RegQ         (RegQ),
        .grant        (grant),
        .deny         (deny),
        .locked       (locked),
        .occupied     (occupied),
        .full         (full),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle confirm pulse; the caller leaves a gap before the next pulse
    task automatic pulse();
        confirm = 1'b1;
        step();
        confirm = 1'b0;
    endtask

    task automatic grant_session(input string tag, input logic [2:0] exp_occ);
        request = 1'b1;
        step();
        pulse();
        chk({tag, "_armed"}, 32'(state), 2);
        step();
        pulse();
        chk({tag, "_grant"}, 32'(grant), 1);
        chk({tag, "_occ"}, 32'(occupied), 32'(exp_occ));
        request = 1'b0;
        step();
        chk({tag, "_idle"}, 32'(state), 0);
    endtask

    task automatic deny_session(input string tag, input logic [2:0] exp_state);
        request = 1'b1;
        step();
        pulse();
        chk({tag, "_state"}, 32'(state), 32'(exp_state));
        request = 1'b0;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        request      = 1'b0;
        confirm      = 1'b0;
        system_token = 3'b101;
        user_token   = 3'b101;
        TimeData     = 8'h00;
        car_exit     = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_state", 32'(state), 0);
        chk("rst_outs", 32'({RegP, RegQ, grant, deny, locked, full}), 0);
        chk("rst_occ", 32'(occupied), 0);

        // Happy path, peak tariff
        request = 1'b1;
        step();
        chk("hp_auth", 32'(state), 1);
        pulse();
        chk("hp_armed", 32'(state), 2);
        chk("hp_nogrant", 32'(grant), 0);
        step();
        TimeData = 8'h1F;
        pulse();
        chk("hp_bill", 32'(state), 3);
        chk("hp_grant", 32'(grant), 1);
        chk("hp_tariff", 32'({RegP, RegQ}), 2'b10);
        chk("hp_occ", 32'(occupied), 1);
        step();
        chk("hp_grant_once", 32'(grant), 0);
        chk("hp_hold_tariff", 32'({RegP, RegQ}), 2'b10);
        request = 1'b0;
        step();
        chk("hp_drop_state", 32'(state), 0);
        chk("hp_drop_tariff", 32'({RegP, RegQ}), 0);

        // Held confirm counts once, then off-peak grant
        request = 1'b1;
        step();
        confirm = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("held_armed", 32'(state), 2);
        chk("held_nogrant", 32'(grant), 0);
        chk("held_occ", 32'(occupied), 1);
        confirm = 1'b0;
        step();
        TimeData = 8'h1E;
        pulse();
        chk("op_grant", 32'(grant), 1);
        chk("op_tariff", 32'({RegP, RegQ}), 2'b01);
        chk("op_occ", 32'(occupied), 2);
        request = 1'b0;
        step();

        // Lockout after three consecutive mismatches
        user_token = 3'b010;
        request = 1'b1;
        step();
        pulse();
        chk("lk_s1_deny_state", 32'(state), 4);
        chk("lk_s1_deny", 32'(deny), 1);
        step();
        chk("lk_s1_deny_hold", 32'(deny), 1);
        request = 1'b0;
        step();
        chk("lk_s1_idle", 32'({state, deny}), 0);
        deny_session("lk_s2", 3'd4);
        request = 1'b1;
        step();
        pulse();
        chk("lk_enter", 32'({state, locked}), {3'd5, 1'b1});
        lock_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!locked) break;
            lock_cnt++;
        end
        chk("lk_cycles", 32'(lock_cnt), 16);
        chk("lk_exit_idle", 32'(state), 0);
        step();
        chk("lk_reauth", 32'(state), 1);
        pulse();
        chk("lk_tries_cleared", 32'(state), 4);
        request = 1'b0;
        step();

        // Capacity: fill, deny while full without counting tries, free a slot
        user_token = 3'b101;
        grant_session("fill3", 3'd3);
        grant_session("fill4", 3'd4);
        chk("full_set", 32'(full), 1);
        user_token = 3'b010;
        deny_session("full_d1", 3'd4);
        deny_session("full_d2", 3'd4);
        car_exit = 1'b1;
        step();
        car_exit = 1'b0;
        chk("exit_occ", 32'(occupied), 3);
        chk("exit_notfull", 32'(full), 0);
        deny_session("full_tries_kept", 3'd4);
        user_token = 3'b101;
        grant_session("refill", 3'd4);
        car_exit = 1'b1;
        step();
        car_exit = 1'b0;
        chk("exit2_occ", 32'(occupied), 3);

        // Grant and car_exit on the same edge
        request = 1'b1;
        step();
        pulse();
        step();
        confirm  = 1'b1;
        car_exit = 1'b1;
        step();
        confirm  = 1'b0;
        car_exit = 1'b0;
        chk("sim_grant", 32'(grant), 1);
        chk("sim_occ", 32'(occupied), 3);
        request = 1'b0;
        step();

        // Reset while in BILL
        request = 1'b1;
        step();
        pulse();
        step();
        pulse();
        chk("rb_bill", 32'({state, occupied}), {3'd3, 3'd4});
        reset = 1'b1;
        step();
        reset   = 1'b0;
        request = 1'b0;
        chk("rb_state", 32'(state), 0);
        chk("rb_outs", 32'({RegP, RegQ, grant, deny, locked, full}), 0);
        chk("rb_occ", 32'(occupied), 0);
        car_exit = 1'b1;
        step();
        car_exit = 1'b0;
        chk("exit_at_zero", 32'(occupied), 0);

        // Reset in the middle of a lockout
        user_token = 3'b010;
        deny_session("rl_d1", 3'd4);
        deny_session("rl_d2", 3'd4);
        request = 1'b1;
        step();
        pulse();
        chk("rl_lock", 32'(state), 5);
        for (int i = 0; i < 9; i++) step();
        chk("rl_still_locked", 32'({state, locked}), {3'd5, 1'b1});
        reset = 1'b1;
        request = 1'b0;
        step();
        reset = 1'b0;
        chk("rl_state", 32'(state), 0);
        chk("rl_outs", 32'({RegP, RegQ, grant, deny, locked, full}), 0);
        chk("rl_occ", 32'(occupied), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
